// File: rtl/receiver.sv
// receiver: parses 8-byte command frames from the host RX FIFO and unpacks
// little-endian burst payloads into 32-bit phase words.
module receiver #(
  parameter int TX_FIFO_LOAD_W = 13,
  parameter int RX_FIFO_LOAD_W = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rxfifo_data,
  input  logic                      rxfifo_valid,
  input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
  input  logic                      rxfifo_empty,
  output logic                      rxfifo_rd,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  input  logic                      txfifo_full,
  output logic                      txfifo_wr,
  output logic [7:0]                txfifo_data,
  output logic                      read_error,
  output logic                      phase_parse_en,
  output logic                      phase_calib_en,
  output logic [31:0]               latest_data,
  output logic                      global_enable
);
  typedef enum logic {FRAME, BURST} state_t;
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] d_q, d_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] n_q, n_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] latest_q, latest_d;
  logic        ge_q, ge_d;
  logic [7:0]  txd_q, txd_d;
  logic        txwr_q, txwr_d;
  logic        rerr_q, rerr_d;
  logic        pp_q, pp_d;
  logic        pc_q, pc_d;
  logic [31:0] packed_w;
  logic        unused_load;
  assign unused_load = ^{rxfifo_load, txfifo_load};
  assign rxfifo_rd = rst & ~rxfifo_empty;
  assign packed_w = word_q | ({24'd0, rxfifo_data} << {cnt_q, 3'b000});
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    d_d      = d_q;
    code_d   = code_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    latest_d = latest_q;
    ge_d     = ge_q;
    txd_d    = txd_q;
    txwr_d   = 1'b0;
    rerr_d   = 1'b0;
    pp_d     = 1'b0;
    pc_d     = 1'b0;
    if (rxfifo_valid && state_q == BURST) begin
      n_d    = n_q - 32'd1;
      cnt_d  = cnt_q + 2'd1;
      word_d = packed_w;
      // A word is emitted when full or when the burst runs out (upper bytes stay zero).
      if (cnt_q == 2'd3 || n_q == 32'd1) begin
        latest_d = packed_w;
        pp_d     = 1'b1;
        word_d   = '0;
        cnt_d    = '0;
      end
      if (n_q == 32'd1) begin
        state_d = FRAME;
        idx_d   = '0;
      end
    end else if (rxfifo_valid) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd0 && rxfifo_data != 8'h55) idx_d = '0;
      if (idx_q >= 3'd1 && idx_q <= 3'd4) d_d = {rxfifo_data, d_q[31:8]};
      if (idx_q == 3'd5) code_d = rxfifo_data;
      if (idx_q == 3'd6 && rxfifo_data != 8'h00) begin
        rerr_d = 1'b1;
        idx_d  = '0;
      end
      if (idx_q == 3'd7) begin
        idx_d = '0;
        if (rxfifo_data != 8'hAA || code_q == 8'h00 || code_q > 8'h04) rerr_d = 1'b1;
        else begin
          txwr_d = ~txfifo_full;
          txd_d  = txfifo_full ? txd_q : code_q;
          case (code_q)
            8'h01: begin latest_d = d_q; pp_d = 1'b1; end
            8'h03: begin latest_d = d_q; pc_d = 1'b1; end
            8'h02: begin
              n_d     = d_q;
              state_d = (d_q != 32'd0) ? BURST : FRAME;
              cnt_d   = '0;
              word_d  = '0;
            end
            default: ge_d = d_q[0];
          endcase
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FRAME;
      idx_q    <= '0;
      d_q      <= '0;
      code_q   <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      latest_q <= '0;
      ge_q     <= 1'b0;
      txd_q    <= '0;
      txwr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      pp_q     <= 1'b0;
      pc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      d_q      <= d_d;
      code_q   <= code_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      latest_q <= latest_d;
      ge_q     <= ge_d;
      txd_q    <= txd_d;
      txwr_q   <= txwr_d;
      rerr_q   <= rerr_d;
      pp_q     <= pp_d;
      pc_q     <= pc_d;
    end
  end
  assign txfifo_wr      = txwr_q;
  assign txfifo_data    = txd_q;
  assign read_error     = rerr_q;
  assign phase_parse_en = pp_q;
  assign phase_calib_en = pc_q;
  assign latest_data    = latest_q;
  assign global_enable  = ge_q;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: randomized byte streams checked cycle by cycle against a queue-based frame/burst model.
module tb_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rxfifo_data = '0;
  logic        rxfifo_valid = 1'b0;
  logic [12:0] rxfifo_load = '0;
  logic        rxfifo_empty = 1'b1;
  logic        rxfifo_rd;
  logic [12:0] txfifo_load = '0;
  logic        txfifo_full = 1'b0;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;
  logic        read_error, phase_parse_en, phase_calib_en, global_enable;
  logic [31:0] latest_data;

  receiver dut (
    .clk(clk), .rst(rst), .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid),
    .rxfifo_load(rxfifo_load), .rxfifo_empty(rxfifo_empty), .rxfifo_rd(rxfifo_rd),
    .txfifo_load(txfifo_load), .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
    .txfifo_data(txfifo_data), .read_error(read_error), .phase_parse_en(phase_parse_en),
    .phase_calib_en(phase_calib_en), .latest_data(latest_data), .global_enable(global_enable)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0]  fq[$];
  logic [7:0]  bq[$];
  logic        m_burst = 1'b0;
  logic [31:0] m_n = '0;
  logic [31:0] m_latest = '0;
  logic        m_ge = 1'b0;
  logic [7:0]  m_txd = '0;
  logic        e_err = 1'b0, e_pp = 1'b0, e_pc = 1'b0, e_wr = 1'b0;
  bit          gap_en = 1'b0;

  task automatic model_reset();
    fq.delete(); bq.delete();
    m_burst = 1'b0; m_n = '0; m_latest = '0; m_ge = 1'b0; m_txd = '0;
    {e_err, e_pp, e_pc, e_wr} = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic f);
    logic [31:0] w, d;
    logic [7:0]  code;
    {e_err, e_pp, e_pc, e_wr} = '0;
    if (m_burst) begin
      bq.push_back(b);
      m_n = m_n - 1;
      if (bq.size() == 4 || m_n == 0) begin
        w = '0;
        foreach (bq[i]) w = w | (32'(bq[i]) << (8 * i));
        m_latest = w; e_pp = 1'b1; bq.delete();
      end
      if (m_n == 0) m_burst = 1'b0;
      return;
    end
    if (fq.size() == 0 && b != 8'h55) return;
    fq.push_back(b);
    if (fq.size() == 7 && b != 8'h00) begin
      e_err = 1'b1; fq.delete();
    end else if (fq.size() == 8) begin
      d = {fq[4], fq[3], fq[2], fq[1]};
      code = fq[5];
      fq.delete();
      if (b != 8'hAA || code < 1 || code > 4) e_err = 1'b1;
      else begin
        if (!f) begin e_wr = 1'b1; m_txd = code; end
        if (code == 1) begin m_latest = d; e_pp = 1'b1; end
        if (code == 3) begin m_latest = d; e_pc = 1'b1; end
        if (code == 2 && d != 0) begin m_burst = 1'b1; m_n = d; end
        if (code == 4) m_ge = d[0];
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b, input logic f, input logic e);
    @(negedge clk);
    chk("read_error", 32'(read_error), 32'(e_err));
    chk("phase_parse_en", 32'(phase_parse_en), 32'(e_pp));
    chk("phase_calib_en", 32'(phase_calib_en), 32'(e_pc));
    chk("txfifo_wr", 32'(txfifo_wr), 32'(e_wr));
    chk("txfifo_data", 32'(txfifo_data), 32'(m_txd));
    chk("latest_data", latest_data, m_latest);
    chk("global_enable", 32'(global_enable), 32'(m_ge));
    rst = r; rxfifo_valid = v; rxfifo_data = b; txfifo_full = f; rxfifo_empty = e;
    #1 chk("rxfifo_rd", 32'(rxfifo_rd), 32'(r & ~e));
    if (!r) model_reset();
    else if (v) model_byte(b, f);
    else {e_err, e_pp, e_pc, e_wr} = '0;
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    if (gap_en) begin
      int g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < g; i++) step(1'b1, 1'b0, 8'($urandom), f, 1'($urandom));
    end
    step(1'b1, 1'b1, b, f, 1'($urandom));
  endtask

  task automatic send_frame(input logic [31:0] d, input logic [7:0] code, input logic f);
    send(8'h55, f); send(d[7:0], f); send(d[15:8], f); send(d[23:16], f); send(d[31:24], f);
    send(code, f); send(8'h00, f); send(8'hAA, f);
  endtask

  initial begin
    logic [7:0]  fr[8];
    logic [31:0] d;
    logic [7:0]  code;
    logic        f;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_latest", latest_data, 32'h0);
    send_frame(32'h00010123, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("req40_latest", latest_data, 32'h00010123);
    send_frame(32'h00000023, 8'h03, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("req41_latest", latest_data, 32'h00000023);
    send_frame(32'h00000010, 8'h02, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("req42_latest", latest_data, 32'h0F0E0D0C);
    send_frame(32'h00000005, 8'h02, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("req43_latest", latest_data, 32'h00000055);
    send(8'h55, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'hAB, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("req44_latest", latest_data, 32'h00000055);
    send_frame(32'h00000001, 8'h04, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("req45_ge", 32'(global_enable), 32'h1);
    gap_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 5))
        0: code = 8'h01;
        1: code = 8'h02;
        2: code = 8'h03;
        3: code = 8'h04;
        default: code = 8'($urandom);
      endcase
      d = (code == 8'h02) ? 32'($urandom_range(0, 9)) : $urandom;
      f = ($urandom_range(0, 3) == 0);
      fr[0] = 8'h55; fr[1] = d[7:0]; fr[2] = d[15:8]; fr[3] = d[23:16]; fr[4] = d[31:24];
      fr[5] = code; fr[6] = 8'h00; fr[7] = 8'hAA;
      if ($urandom_range(0, 7) == 0) fr[6] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) fr[7] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) send(8'($urandom), f);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          step(1'b0, 1'b1, 8'h55, f, 1'b0);
          step(1'b0, 1'b0, 8'h00, f, 1'b1);
        end
        send(fr[i], f);
      end
      while (m_burst) send(8'($urandom), f);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter TX_FIFO_LOAD_W, default 13, width of the TX FIFO fill-level input.
REQ-002 Parameter RX_FIFO_LOAD_W, default 13, width of the RX FIFO fill-level input.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (rst=0 resets).
REQ-005 rxfifo_data  input  8  byte from the host RX FIFO.
REQ-006 rxfifo_valid  input  1  rxfifo_data is valid this cycle.
REQ-007 rxfifo_load  input  RX_FIFO_LOAD_W  RX FIFO fill level; informational, unused.
REQ-008 rxfifo_empty  input  1  RX FIFO empty.
REQ-009 rxfifo_rd  output  1  RX FIFO read request.
REQ-010 txfifo_load  input  TX_FIFO_LOAD_W  TX FIFO fill level; informational, unused.
REQ-011 txfifo_full  input  1  TX FIFO full.
REQ-012 txfifo_wr  output  1  TX FIFO write strobe.
REQ-013 txfifo_data  output  8  byte to the TX FIFO.
REQ-014 read_error  output  1  one-cycle pulse on a malformed frame.
REQ-015 phase_parse_en  output  1  one-cycle pulse: latest_data holds a new phase word.
REQ-016 phase_calib_en  output  1  one-cycle pulse: latest_data holds a calibration word.
REQ-017 latest_data  output  32  most recent command payload or packed burst word.
REQ-018 global_enable  output  1  registered global output-enable flag.

Function
REQ-019 rxfifo_rd SHALL be high whenever rst=1 and rxfifo_empty=0, and low otherwise.
REQ-020 A byte SHALL be consumed on every clock edge where rxfifo_valid=1; no other input qualifies it.
REQ-021 Frame format, in arrival order, SHALL be 8 bytes: 0x55, D[7:0], D[15:8], D[23:16], D[31:24], CODE, 0x00, 0xAA.
REQ-022 In state FRAME, a byte index 0..7 SHALL advance per consumed byte.
REQ-023 A mismatch at index 0 SHALL be discarded silently, with the index kept at 0 (hunt for sync).
REQ-024 A mismatch of the fixed bytes at index 6 or 7 SHALL pulse read_error for one cycle, discard the frame and reset the index to 0.
REQ-025 On a valid frame, the response SHALL begin in the cycle after the 0xAA byte is consumed (1-cycle latency).
REQ-026 CODE 0x01 SHALL set latest_data=D and pulse phase_parse_en.
REQ-027 CODE 0x03 SHALL set latest_data=D and pulse phase_calib_en.
REQ-028 CODE 0x02 SHALL load the burst count N=D and enter state BURST if N>0.
REQ-029 CODE 0x02 with N=0 SHALL leave the receiver in state FRAME.
REQ-030 CODE 0x04 SHALL set global_enable=D[0] and leave latest_data unchanged.
REQ-031 Any other CODE SHALL pulse read_error and take no other action.
REQ-032 On every valid frame (codes 0x01-0x04), txfifo_wr SHALL pulse with txfifo_data=CODE in the response cycle if txfifo_full=0; if full, the acknowledge is dropped.
REQ-033 In BURST, each consumed byte SHALL be packed little-endian into a 32-bit word, no sync/code checking, N decremented per byte.
REQ-034 In BURST, every 4th byte SHALL update latest_data and pulse phase_parse_en in the next cycle.
REQ-035 When N reaches 0 in BURST, any partial word SHALL be zero-padded in the upper bytes, emitted as in REQ-034, and the state SHALL return to FRAME with index 0.
REQ-036 rxfifo_valid=0 SHALL freeze all parsing state; gaps mid-frame or mid-burst are legal.
REQ-037 Pulse outputs SHALL be high for exactly one cycle per event, and read_error SHALL never assert in BURST.

Reset
REQ-038 While rst=0: rxfifo_rd=0, txfifo_wr=0, txfifo_data=0, read_error=0, phase_parse_en=0, phase_calib_en=0, latest_data=0, global_enable=0, state=FRAME, index=0, N=0.
REQ-039 Reset asserted mid-frame or mid-burst SHALL discard partial data, and the first byte after release SHALL be treated as index 0.

Verification
REQ-040 Bytes 55 23 01 01 00 01 00 AA -> latest_data=0x00010123, one phase_parse_en pulse, txfifo_wr with txfifo_data=0x01.
REQ-041 Bytes 55 23 00 00 00 03 00 AA -> latest_data=0x00000023, one phase_calib_en pulse, no phase_parse_en.
REQ-042 Bytes 55 10 00 00 00 02 00 AA then bytes 0x00..0x0F -> four phase_parse_en pulses, latest_data=0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then back to FRAME.
REQ-043 Burst N=5 with bytes 11 22 33 44 55 -> words 0x44332211, then 0x00000055.
REQ-044 Bytes 55 01 00 00 00 01 00 AB -> read_error pulse, no phase_parse_en, latest_data unchanged.
REQ-045 Code 0x04 with D=1, and txfifo_full=1 -> global_enable=1, txfifo_wr stays 0.
